// File: rtl/ddfs_phase_gen.sv
// Phase accumulator and quadrant fold feeding a CORDIC stage with Q4.28 angles.
// Optional feature: define PHASE_OFFSET_EN to add a phase_offset input added to the accumulator.
module ddfs_phase_gen (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [31:0] ftw_in,
   input  logic        ftw_wr,
`ifdef PHASE_OFFSET_EN
   input  logic [31:0] phase_offset,
`endif
   input  logic        out_ready,
   output logic [31:0] angle_out,
   output logic        neg_out,
   output logic [8:0]  sample_idx,
   output logic        out_valid
);

   // round(pi/8 * 2^30): maps a quarter turn (2^30) onto pi/2 in Q4.28.
   localparam logic signed [63:0] ANGLE_SCALE = 64'sd421657428;

   logic [31:0] acc_q, acc_d;
   logic [31:0] ftw_q, ftw_d;
   logic [31:0] theta_q, theta_d;
   logic        s1_neg_q, s1_neg_d;
   logic        s1_valid_q, s1_valid_d;
   logic [31:0] angle_q, angle_d;
   logic        neg_q, neg_d;
   logic        out_valid_q, out_valid_d;
   logic [8:0]  idx_q, idx_d;

   logic               stall;
   logic [31:0]        phase;
   logic               fold;
   logic signed [63:0] theta_ext;

   // Handshake: a sample transfers on an edge where out_valid=1 and out_ready=1;
   // out_valid never drops and angle_out/neg_out never change while out_ready=0.
   always_comb begin
      stall       = out_valid_q & ~out_ready;
`ifdef PHASE_OFFSET_EN
      phase       = acc_q + phase_offset;
`else
      phase       = acc_q;
`endif
      fold        = phase[31] ^ phase[30];
      theta_ext   = {{32{theta_q[31]}}, theta_q};

      acc_d       = acc_q;
      ftw_d       = ftw_q;
      theta_d     = theta_q;
      s1_neg_d    = s1_neg_q;
      s1_valid_d  = s1_valid_q;
      angle_d     = angle_q;
      neg_d       = neg_q;
      out_valid_d = out_valid_q;
      idx_d       = idx_q;

      if (ftw_wr) begin
         ftw_d = ftw_in;
      end

      if (!stall) begin
         s1_valid_d = enable;
         if (enable) begin
            acc_d    = acc_q + ftw_q;
            // Quadrants 1/2 shift by half a turn (flip bit 31); quadrant 3 is already p - 2^32.
            theta_d  = fold ? {~phase[31], phase[30:0]} : phase;
            s1_neg_d = fold;
         end
         out_valid_d = s1_valid_q;
         angle_d     = 32'((theta_ext * ANGLE_SCALE) >>> 30);
         neg_d       = s1_neg_q;
      end

      if (out_valid_q && out_ready) begin
         idx_d = (idx_q == 9'd359) ? 9'd0 : idx_q + 9'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q       <= '0;
         ftw_q       <= '0;
         theta_q     <= '0;
         s1_neg_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         angle_q     <= '0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
      end else begin
         acc_q       <= acc_d;
         ftw_q       <= ftw_d;
         theta_q     <= theta_d;
         s1_neg_q    <= s1_neg_d;
         s1_valid_q  <= s1_valid_d;
         angle_q     <= angle_d;
         neg_q       <= neg_d;
         out_valid_q <= out_valid_d;
         idx_q       <= idx_d;
      end
   end

   assign angle_out  = angle_q;
   assign neg_out    = neg_q;
   assign sample_idx = idx_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_ddfs_phase_gen.sv
// Self-checking bench for ddfs_phase_gen: directed table, corner sequences and random traffic
// against a phase-to-angle reference model.
module tb_ddfs_phase_gen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] ftw_in = '0;
   logic        ftw_wr = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] angle_out;
   logic        neg_out;
   logic [8:0]  sample_idx;
   logic        out_valid;
`ifdef PHASE_OFFSET_EN
   logic [31:0] phase_offset = '0;
`endif

   always #5 clk = ~clk;

   ddfs_phase_gen dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .ftw_in     (ftw_in),
      .ftw_wr     (ftw_wr),
`ifdef PHASE_OFFSET_EN
      .phase_offset (phase_offset),
`endif
      .out_ready  (out_ready),
      .angle_out  (angle_out),
      .neg_out    (neg_out),
      .sample_idx (sample_idx),
      .out_valid  (out_valid)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Scoreboard: {neg, angle} of every sample produced, in order; got_q logs accepted DUT samples.
   logic [32:0] exp_q[$];
   logic [32:0] got_q[$];
   logic [31:0] m_acc;
   logic [31:0] m_ftw;
   logic        m_s1v;
   logic        m_ov;
   int          m_idx;
   int          m_adv;

   typedef struct {
      logic [31:0] ftw;
      int          k;
      logic [31:0] angle;
      logic        neg;
   } vec_t;
   vec_t tbl[12];

   function automatic logic [31:0] m_off();
`ifdef PHASE_OFFSET_EN
      return phase_offset;
`else
      return 32'd0;
`endif
   endfunction

   // Angle from a phase: map the phase into [-quarter, +quarter) turn, then scale a quarter turn to pi/2.
   function automatic logic [32:0] ref_sample(input logic [31:0] p);
      longint ph;
      longint theta;
      longint ang;
      logic   neg;
      ph = longint'({32'd0, p});
      if (ph < 64'sd1073741824) begin
         theta = ph;
         neg   = 1'b0;
      end else if (ph < 64'sd3221225472) begin
         theta = ph - 64'sd2147483648;
         neg   = 1'b1;
      end else begin
         theta = ph - 64'sd4294967296;
         neg   = 1'b0;
      end
      ang = (theta * 64'sd421657428) >>> 30;
      return {neg, ang[31:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = '0;
      m_ftw = '0;
      m_s1v = 1'b0;
      m_ov  = 1'b0;
      m_idx = 0;
      m_adv = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   // Check presented outputs, advance the model by one edge, then clock the DUT.
   task automatic step();
      logic stall;
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("sample_idx", 64'(sample_idx), 64'(m_idx));
      if (m_ov) begin
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'd1, 64'd0);
         end else begin
            check("angle", 64'(angle_out), 64'(exp_q[0][31:0]));
            check("neg", 64'(neg_out), 64'(exp_q[0][32]));
         end
      end
      stall = m_ov && !out_ready;
      if (m_ov && out_ready) begin
         got_q.push_back({neg_out, angle_out});
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         m_idx = (m_idx + 1) % 360;
      end
      if (!stall) begin
         m_ov  = m_s1v;
         m_s1v = enable;
         if (enable) begin
            exp_q.push_back(ref_sample(m_acc + m_off()));
            m_acc = m_acc + m_ftw;
            m_adv++;
         end
      end
      if (ftw_wr) m_ftw = ftw_in;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      enable    = 1'b0;
      ftw_wr    = 1'b0;
      ftw_in    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_angle", 64'(angle_out), 64'd0);
      check("rst_neg", 64'(neg_out), 64'd0);
      check("rst_idx", 64'(sample_idx), 64'd0);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic write_ftw(input logic [31:0] w);
      ftw_in = w;
      ftw_wr = 1'b1;
      step();
      ftw_wr = 1'b0;
   endtask

   task automatic run_until_got(input int n, input int budget);
      int cyc;
      cyc = 0;
      while (got_q.size() < n && cyc < budget) begin
         step();
         cyc++;
      end
      if (got_q.size() < n) check("cycle_budget", 64'd0, 64'd1);
   endtask

   task automatic check_got(input string name, input int k, input logic [31:0] ang, input logic neg);
      if (got_q.size() <= k) begin
         check({name, "_missing"}, 64'd0, 64'd1);
      end else begin
         check({name, "_angle"}, 64'(got_q[k][31:0]), 64'(ang));
         check({name, "_neg"}, 64'(got_q[k][32]), 64'(neg));
      end
   endtask

   initial begin
      logic [31:0] snap_a;
      logic [8:0]  snap_i;

      tbl[0]  = '{32'h4000_0000, 0, 32'd0, 1'b0};
      tbl[1]  = '{32'h4000_0000, 1, -32'sd421657428, 1'b1};
      tbl[2]  = '{32'h4000_0000, 2, 32'd0, 1'b1};
      tbl[3]  = '{32'h4000_0000, 3, -32'sd421657428, 1'b0};
      tbl[4]  = '{32'h4000_0000, 4, 32'd0, 1'b0};
      tbl[5]  = '{32'h2000_0000, 1, 32'd210828714, 1'b0};
      tbl[6]  = '{32'h2000_0000, 3, -32'sd210828714, 1'b1};
      tbl[7]  = '{32'h2000_0000, 5, 32'd210828714, 1'b1};
      tbl[8]  = '{32'h2000_0000, 7, -32'sd210828714, 1'b0};
      tbl[9]  = '{32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0};
      tbl[10] = '{32'h3FFF_FFFF, 1, 32'd421657427, 1'b0};
      tbl[11] = '{32'hC000_0000, 1, -32'sd421657428, 1'b0};

      // Latency: out_valid rises on the second edge after enable.
      do_reset();
      write_ftw(32'h4000_0000);
      enable    = 1'b1;
      out_ready = 1'b1;
      check("lat_edge0", 64'(out_valid), 64'd0);
      step();
      check("lat_edge1", 64'(out_valid), 64'd0);
      step();
      check("lat_edge2", 64'(out_valid), 64'd1);
      repeat (6) step();

      // Backpressure: five stalled cycles freeze outputs and index.
      snap_a    = angle_out;
      snap_i    = sample_idx;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_angle", 64'(angle_out), 64'(snap_a));
         check("stall_idx", 64'(sample_idx), 64'(snap_i));
         check("stall_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      repeat (10) step();

      // Enable drop drains what is already in flight.
      enable = 1'b0;
      repeat (5) step();
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      for (int t = 0; t < 12; t++) begin
         do_reset();
         write_ftw(tbl[t].ftw);
         enable = 1'b1;
         run_until_got(tbl[t].k + 1, 40);
         check_got($sformatf("tbl%0d", t), tbl[t].k, tbl[t].angle, tbl[t].neg);
      end

      // Tuning-word change coinciding with the fourth advance.
      do_reset();
      write_ftw(32'h4000_0000);
      enable = 1'b1;
      for (int i = 0; i < 30 && got_q.size() < 6; i++) begin
         ftw_wr = (m_adv == 3);
         ftw_in = (m_adv == 3) ? 32'h1000_0000 : 32'h0;
         step();
      end
      ftw_wr = 1'b0;
      check_got("ftw_old3", 3, -32'sd421657428, 1'b0);
      check_got("ftw_old4", 4, 32'd0, 1'b0);
      check_got("ftw_new5", 5, 32'd105414357, 1'b0);

      // 360 transfers at ~1 degree per sample: index and accumulator both wrap.
      do_reset();
      write_ftw(32'd11930465);
      enable = 1'b1;
      run_until_got(360, 500);
      check("wrap_idx", 64'(sample_idx), 64'd0);
      run_until_got(361, 20);
      check_got("wrap_first", 0, 32'd0, 1'b0);
      check_got("wrap_361", 360, 32'd40, 1'b0);

      // Asynchronous reset between edges while a sample is presented.
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_angle", 64'(angle_out), 64'd0);
      check("async_idx", 64'(sample_idx), 64'd0);
      check("async_neg", 64'(neg_out), 64'd0);
      enable = 1'b0;
      @(posedge clk);
      #1;

      // Random traffic against the model.
      do_reset();
      write_ftw($urandom);
      for (int i = 0; i < 3000; i++) begin
         enable    = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         ftw_wr    = ($urandom_range(0, 31) == 0);
         ftw_in    = $urandom;
         step();
      end
      ftw_wr = 1'b0;

`ifdef PHASE_OFFSET_EN
      phase_offset = 32'h8000_0000;
      do_reset();
      write_ftw(32'h4000_0000);
      enable = 1'b1;
      run_until_got(1, 20);
      check_got("offset_first", 0, 32'd0, 1'b1);
      phase_offset = 32'h0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
